// File: rtl/mips_pkg.sv
// Shared Mini-MIPS definitions: HI/LO multiply/accumulate op codes, controller
// state encoding and the default datapath width.
package mips_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] MAC_MUL   = 3'd0;
  localparam logic [2:0] MAC_MULT  = 3'd1;
  localparam logic [2:0] MAC_MULTU = 3'd2;
  localparam logic [2:0] MAC_MADD  = 3'd3;
  localparam logic [2:0] MAC_MADDU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ACC,
    ST_DONE
  } mac_state_e;

  function automatic logic is_signed_op(input logic [2:0] code);
    return (code == MAC_MUL) || (code == MAC_MULT) || (code == MAC_MADD);
  endfunction

endpackage

// File: rtl/hilo_mac_ctrl_mult_iter.sv
// Shift-add multiplier datapath: one conditional add plus right shift per step,
// multiplier held in the low half of the partial product.
module mult_iter #(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   prod
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     upper_sum;

  always_comb begin
    // Carry out of the upper-half add becomes the new MSB after the shift.
    upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    if (load) begin
      mcand_d = multiplicand;
      prod_d  = {{WIDTH{1'b0}}, multiplier};
    end else if (step) begin
      prod_d = {upper_sum, prod_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/hilo_mac_ctrl.sv
// HI/LO owner for the execute stage: sequences MUL/MULT/MULTU/MADD/MADDU through
// a 32-step shift-add multiplier, then applies sign and accumulates into HI/LO.
module hilo_mac_ctrl #(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_pkg::*;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               sgn_in;
  logic               mult_load;
  logic               mult_step;
  logic [WIDTH-1:0]   mcand_mag;
  logic [WIDTH-1:0]   mplier_mag;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] acc_sum;

  // Signed ops multiply magnitudes; 0x80000000 negates to itself, read unsigned.
  assign sgn_in     = is_signed_op(op);
  assign mcand_mag  = (sgn_in && input1[WIDTH-1]) ? (~input1 + 1'b1) : input1;
  assign mplier_mag = (sgn_in && input2[WIDTH-1]) ? (~input2 + 1'b1) : input2;
  assign mult_load  = (state_q == ST_IDLE) && start;
  assign mult_step  = (state_q == ST_CALC);

  mult_iter #(.WIDTH(WIDTH)) u_mult_iter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (mult_load),
    .step         (mult_step),
    .multiplicand (mcand_mag),
    .multiplier   (mplier_mag),
    .prod         (prod_raw)
  );

  assign prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
  assign acc_sum  = {hi_q, lo_q} + prod_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = op;
          neg_d   = sgn_in & (input1[WIDTH-1] ^ input2[WIDTH-1]);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        case (op_q)
          MAC_MUL: result_d = prod_fix[WIDTH-1:0];
          MAC_MULT, MAC_MULTU: begin
            {hi_d, lo_d} = prod_fix;
            result_d     = prod_fix[WIDTH-1:0];
          end
          MAC_MADD, MAC_MADDU: begin
            {hi_d, lo_d} = acc_sum;
            result_d     = prod_fix[WIDTH-1:0];
          end
          default: ;
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle raises the pulse; second drops it and frees the unit.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_hilo_mac_ctrl.sv
// Self-checking bench for hilo_mac_ctrl: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic model of HI/LO/result.
module tb_hilo_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] result, hi, lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [31:0] res_m = '0;

  localparam int EXP_LAT = 35;  // negedges from start setup to done: done follows E34

  hilo_mac_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .input1(in1), .input2(in2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_prod(input logic [2:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (code == 3'd0 || code == 3'd1 || code == 3'd3) return 64'(sa * sb);
    return 64'(ua * ub);
  endfunction

  task automatic model_apply(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = model_prod(code, a, b);
    case (code)
      3'd0: res_m = p[31:0];
      3'd1, 3'd2: begin {hi_m, lo_m} = p; res_m = p[31:0]; end
      3'd3, 3'd4: begin {hi_m, lo_m} = {hi_m, lo_m} + p; res_m = p[31:0]; end
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op_i = code; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0; op_i = 3'($urandom); in1 = $urandom; in2 = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (done === 1'b1) begin lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    do_start(code, a, b);
    model_apply(code, a, b);
    wait_done(lat);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h result=%h lat=%0d", code, a, b, hi, lo, result, lat);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_basic;
    int lat;
    do_start(3'd1, 32'd6, 32'd7);
    model_apply(3'd1, 32'd6, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_early: got %b want 1", busy); end
    wait_done(lat);
    $display("op=1 a=6 b=7 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL mult_latency: got %0d want %0d", lat, EXP_LAT); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_done: got %b want 1", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL mult_6x7: got %h_%h want 0_2a", hi, lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mult_after: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_madd;
    int lat;
    run_op(3'd3, 32'd3, 32'd4, lat);
    checks++; if (hi !== 32'd0 || lo !== 32'd54) begin errors++; $display("FAIL madd_3x4: got %h_%h want 0_36", hi, lo); end
    @(negedge clk);
    run_op(3'd4, 32'd5, 32'd6, lat);
    checks++; if (hi !== 32'd0 || lo !== 32'd84) begin errors++; $display("FAIL maddu_5x6: got %h_%h want 0_54", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_edges;
    int lat;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if ({hi, lo} !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL mult_m1m1: got %h_%h want 00000000_00000001", hi, lo); end
    @(negedge clk);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo); end
    @(negedge clk);
    run_op(3'd1, 32'h8000_0000, 32'd2, lat);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL mult_minint: got %h_%h want ffffffff_00000000", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_mul_mt;
    int lat;
    hi_we = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5555;
    @(negedge clk);
    lo_we = 1'b0;
    hi_m = 32'hAAAA_0000; lo_m = 32'h0000_5555;
    checks++; if (hi !== hi_m || lo !== lo_m) begin errors++; $display("FAIL mt_write: got %h_%h want %h_%h", hi, lo, hi_m, lo_m); end
    run_op(3'd0, 32'd0, 32'd10, lat);
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL mul_result: got %h want 0", result); end
    checks++; if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555) begin errors++; $display("FAIL mul_hilo_kept: got %h_%h want aaaa0000_00005555", hi, lo); end
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    hi_m = 32'h1234; lo_m = 32'h1234;
    checks++; if (hi !== 32'h1234 || lo !== 32'h1234) begin errors++; $display("FAIL mt_both: got %h_%h want 00001234_00001234", hi, lo); end
    // MTLO on the same edge as a MADD launch: accumulate sees the new LO.
    lo_we = 1'b1; wdata = 32'd100;
    lo_m = 32'd100;
    do_start(3'd3, 32'd2, 32'd3);
    lo_we = 1'b0;
    model_apply(3'd3, 32'd2, 32'd3);
    wait_done(lat);
    $display("op=3 a=2 b=3 with mtlo=100 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (hi !== 32'h1234 || lo !== 32'd106) begin errors++; $display("FAIL mt_with_start: got %h_%h want 00001234_0000006a", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int lat;
    int extra_done;
    do_start(3'd1, 32'd6, 32'd7);
    model_apply(3'd1, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1; op_i = 3'd2; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat);
    $display("op=1 a=6 b=7 with mid-op start/mthi -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lat === 0) begin errors++; $display("FAIL ignore_timeout: got no done want done"); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL ignore_hilo: got %h_%h want 0_2a", hi, lo); end
    @(negedge clk);
    extra_done = 0;
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra_done++;
      @(negedge clk);
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL ignore_single_done: got %0d busy/done cycles want 0", extra_done); end
  endtask

  task automatic test_reset_mid;
    int lat;
    do_start(3'd3, 32'h1000, 32'h1000);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if ({hi, lo, result} !== 96'd0) begin errors++; $display("FAIL midrst_data: got %h_%h_%h want 0", hi, lo, result); end
    hi_m = '0; lo_m = '0; res_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd1, 32'd2, 32'd3, lat);
    checks++; if (hi !== 32'd0 || lo !== 32'd6 || lat !== EXP_LAT) begin errors++; $display("FAIL midrst_next: got %h_%h lat=%0d want 0_6 lat=%0d", hi, lo, lat, EXP_LAT); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat;
    logic [2:0]  code;
    logic [31:0] a, b;
    logic [31:0] corner [6];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h8000_0001;
    for (int n = 0; n < 24; n++) begin
      code = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      run_op(code, a, b, lat);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, lat, EXP_LAT); end
      checks++; if (hi !== hi_m || lo !== lo_m) begin errors++; $display("FAIL rand_hilo[%0d] op=%0d: got %h_%h want %h_%h", n, code, hi, lo, hi_m, lo_m); end
      checks++; if (result !== res_m) begin errors++; $display("FAIL rand_result[%0d] op=%0d: got %h want %h", n, code, result, res_m); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(3'd2, 32'd9, 32'd9, lat);
    @(negedge clk);
    do_start(3'd2, 32'd10, 32'd11);
    model_apply(3'd2, 32'd10, 32'd11);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_done(lat);
    $display("op=2 a=10 b=11 back-to-back -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lo !== 32'd110 || lat !== EXP_LAT) begin errors++; $display("FAIL b2b_result: got lo=%h lat=%0d want 6e lat=%0d", lo, lat, EXP_LAT); end
    // A start during the done cycle itself must be dropped.
    start = 1'b1; op_i = 3'd1; in1 = 32'd3; in2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || lo !== 32'd110) begin errors++; $display("FAIL start_in_done: got busy=%b lo=%h want 0 6e", busy, lo); end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_madd();
    test_edges();
    test_mul_mt();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
